// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : Load-use hazard detection and registered forwarding selects for
//            the 8-bit 5-stage pipeline, sitting on the ID side of ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl #(
    parameter int unsigned RADDR_W    = 3,
    parameter bit          R0_ZERO    = 1'b1,
    parameter int unsigned STALLCNT_W = 16
) (
    input  logic                  clk2,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [RADDR_W-1:0]    id_rs,
    input  logic [RADDR_W-1:0]    id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic [RADDR_W-1:0]    id_regwradd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [STALLCNT_W-1:0] stall_count
);

    localparam logic [1:0] c_fwd_rf  = 2'b00;
    localparam logic [1:0] c_fwd_ex  = 2'b10;
    localparam logic [1:0] c_fwd_mem = 2'b01;

    // Shadow of ID/EX and EX/MEM. The WB stage is never a forwarding source
    // (the register file writes before it reads), so it carries no state here.
    logic                  r_ex_v, r_ex_rw, r_ex_mr;
    logic [RADDR_W-1:0]    r_ex_rd;
    logic                  r_mem_v, r_mem_rw;
    logic [RADDR_W-1:0]    r_mem_rd;
    logic [1:0]            r_fwd_a, r_fwd_b;
    logic [STALLCNT_W-1:0] r_stall_count;

    logic                  w_id_valid;
    logic                  w_ex_writer, w_mem_writer;
    logic                  w_need_rs, w_need_rt;
    logic                  w_load_use, w_issue;
    logic [1:0]            w_sel_rs, w_sel_rt;

    // id_valid is ignored while reset is held so the pipe front sees a bubble.
    assign w_id_valid   = id_valid & rst_n;

    assign w_ex_writer  = r_ex_v  & r_ex_rw  & ~(R0_ZERO && (r_ex_rd  == '0));
    assign w_mem_writer = r_mem_v & r_mem_rw & ~(R0_ZERO && (r_mem_rd == '0));

    assign w_need_rs    = w_id_valid & id_use_rs & ~(R0_ZERO && (id_rs == '0));
    assign w_need_rt    = w_id_valid & id_use_rt & ~(R0_ZERO && (id_rt == '0));

    assign w_load_use   = w_ex_writer & r_ex_mr &
                          ((w_need_rs & (r_ex_rd == id_rs)) |
                           (w_need_rt & (r_ex_rd == id_rt)));

    assign w_issue      = w_id_valid & ~flush & ~w_load_use;

    assign stall        = w_load_use & ~flush;
    assign bubble       = flush | w_load_use | ~w_id_valid;

    assign w_sel_rs = (w_ex_writer  & (r_ex_rd  == id_rs)) ? c_fwd_ex  :
                      (w_mem_writer & (r_mem_rd == id_rs)) ? c_fwd_mem : c_fwd_rf;
    assign w_sel_rt = (w_ex_writer  & (r_ex_rd  == id_rt)) ? c_fwd_ex  :
                      (w_mem_writer & (r_mem_rd == id_rt)) ? c_fwd_mem : c_fwd_rf;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v        <= 1'b0;
            r_ex_rw       <= 1'b0;
            r_ex_mr       <= 1'b0;
            r_ex_rd       <= '0;
            r_mem_v       <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_rd      <= '0;
            r_fwd_a       <= c_fwd_rf;
            r_fwd_b       <= c_fwd_rf;
            r_stall_count <= '0;
        end else begin
            r_mem_v  <= r_ex_v;
            r_mem_rw <= r_ex_rw;
            r_mem_rd <= r_ex_rd;
            if (w_issue) begin
                r_ex_v  <= 1'b1;
                r_ex_rw <= id_regwrite;
                r_ex_mr <= id_memread;
                r_ex_rd <= id_regwradd;
            end else begin
                r_ex_v  <= 1'b0;
                r_ex_rw <= 1'b0;
                r_ex_mr <= 1'b0;
                r_ex_rd <= '0;
            end
            // Selects land together with the instruction in ID/EX.
            r_fwd_a <= (w_issue & w_need_rs) ? w_sel_rs : c_fwd_rf;
            r_fwd_b <= (w_issue & w_need_rt) ? w_sel_rt : c_fwd_rf;
            if (stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + STALLCNT_W'(1);
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Purpose  : Directed self-checking bench for id_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam int unsigned c_cw = 4;

    logic            clk2;
    logic            rst_n;
    logic            id_valid;
    logic [2:0]      id_rs, id_rt, id_regwradd;
    logic            id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic            flush;
    logic            stall, bubble;
    logic [1:0]      fwd_a, fwd_b;
    logic [c_cw-1:0] stall_count;

    int n_total = 0;
    int n_bad   = 0;

    id_hazard_ctrl #(
        .RADDR_W    (3),
        .R0_ZERO    (1'b1),
        .STALLCNT_W (c_cw)
    ) u_dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_regwradd (id_regwradd),
        .flush       (flush),
        .stall       (stall),
        .bubble      (bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic urs,
                          input logic [2:0] rt, input logic urt, input logic rw,
                          input logic mr, input logic [2:0] rd, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_use_rs   = urs;
        id_rt       = rt;
        id_use_rt   = urt;
        id_regwrite = rw;
        id_memread  = mr;
        id_regwradd = rd;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    initial begin
        int n_stall;
        int cyc;

        // Reset with a valid instruction presented
        rst_n = 1'b0;
        set_id(1, 3'd2, 1, 3'd3, 1, 1, 1, 3'd4, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 1);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_cnt", stall_count, 0);
        tick();
        tick();
        chk("rst_hold_fwd_a", fwd_a, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("nop_bubble", bubble, 1);
        tick();

        // ALU r2 then consumer of r2 -> EX forward
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 0, 3'd2, 0);
        chk("alu_stall", stall, 0);
        chk("alu_bubble", bubble, 0);
        tick();
        set_id(1, 3'd2, 1, 3'd1, 1, 1, 0, 3'd5, 0);
        chk("dep_alu_stall", stall, 0);
        tick();
        chk("dep_alu_fwd_a", fwd_a, 2'b10);
        chk("dep_alu_fwd_b", fwd_b, 2'b00);

        // Load r3 then consumer on rt -> one stall, then MEM forward
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 1, 3'd3, 0);
        tick();
        set_id(1, 3'd1, 0, 3'd3, 1, 1, 0, 3'd6, 0);
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        tick();
        chk("lu_cnt", stall_count, 1);
        chk("lu_stall_gone", stall, 0);
        chk("lu_bubble_gone", bubble, 0);
        tick();
        chk("lu_fwd_b", fwd_b, 2'b01);
        chk("lu_fwd_a", fwd_a, 2'b00);

        // r4 in EX and r4 in MEM -> EX wins
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 0, 3'd4, 0);
        tick();
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 0, 3'd4, 0);
        tick();
        set_id(1, 3'd4, 1, 3'd0, 0, 0, 0, 3'd0, 0);
        tick();
        chk("prio_fwd_a", fwd_a, 2'b10);

        // r0 is never a hazard or forwarding source
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 0, 3'd0, 0);
        tick();
        set_id(1, 3'd0, 1, 3'd0, 1, 0, 0, 3'd0, 0);
        chk("r0_stall", stall, 0);
        tick();
        chk("r0_fwd_a", fwd_a, 2'b00);
        chk("r0_fwd_b", fwd_b, 2'b00);
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 1, 3'd0, 0);
        tick();
        set_id(1, 3'd0, 1, 3'd0, 0, 0, 0, 3'd0, 0);
        chk("r0_load_stall", stall, 0);
        tick();

        // Load-use coinciding with flush
        set_id(1, 3'd0, 0, 3'd0, 0, 1, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 1, 3'd0, 0, 1, 0, 3'd7, 1);
        chk("fl_stall", stall, 0);
        chk("fl_bubble", bubble, 1);
        tick();
        chk("fl_cnt", stall_count, 1);
        set_id(1, 3'd7, 1, 3'd0, 0, 0, 0, 3'd0, 0);
        chk("fl_ex_empty_stall", stall, 0);
        tick();
        chk("fl_ex_empty_fwd_a", fwd_a, 2'b00);
        set_id(0, 3'd1, 1, 3'd1, 1, 1, 1, 3'd1, 0);
        chk("inv_bubble", bubble, 1);
        chk("inv_stall", stall, 0);
        tick();

        // Self-dependent load r1 <- [r1]: stalls every second cycle
        set_id(1, 3'd1, 1, 3'd0, 0, 1, 1, 3'd1, 0);
        n_stall = 0;
        cyc = 0;
        while (n_stall < (1 << c_cw) + 3 && cyc < 200) begin
            if (stall === 1'b1) n_stall++;
            tick();
            cyc++;
        end
        chk("sat_stalls_seen", n_stall, (1 << c_cw) + 3);
        chk("sat_cnt", stall_count, (1 << c_cw) - 1);

        // Async reset in the middle of a stall cycle
        cyc = 0;
        while (stall !== 1'b1 && cyc < 4) begin
            tick();
            cyc++;
        end
        chk("mid_pre_stall", stall, 1);
        chk("mid_pre_fwd_a", fwd_a, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_bubble", bubble, 1);
        chk("mid_rst_fwd_a", fwd_a, 0);
        chk("mid_rst_cnt", stall_count, 0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_bubble", bubble, 0);
        tick();
        chk("post_rst_fwd_a", fwd_a, 2'b00);
        chk("post_rst_cnt", stall_count, 0);
        chk("post_rst_stall2", stall, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
